// File: rtl/bus_gnrtr_arbiter.sv
// ============================================================================
// Module      : bus_gnrtr_arbiter
// Description : Per-bus round-robin arbiter that pops one packet from a driver
//               FIFO and pushes it to the receiver FIFO(s) named by its
//               destination ID. Macro BCAST_SELF_EN makes broadcasts also
//               reach the source driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_gnrtr_arbiter #(
    parameter int         BITS      = 1,
    parameter int         DRVRS     = 4,
    parameter int         PCKG_SZ   = 16,
    parameter logic [7:0] BROADCAST = 8'hFF
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [BITS-1:0][DRVRS-1:0]                pndng,
    input  logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0]   D_pop,
    output logic [BITS-1:0][DRVRS-1:0]                pop,
    output logic [BITS-1:0][DRVRS-1:0]                push,
    output logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0]   D_push
);

    localparam int IW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_PUSH = 2'd2
    } state_t;

    for (genvar b = 0; b < BITS; b++) begin : g_bus
        state_t             r_state;
        state_t             w_state_nxt;
        logic [IW-1:0]      r_rr;
        logic [IW-1:0]      r_src;
        logic [IW-1:0]      w_grant;
        logic [IW:0]        w_idx;
        logic               w_found;
        logic [PCKG_SZ-1:0] r_pkt;
        logic [PCKG_SZ-1:0] r_dpush;
        logic [DRVRS-1:0]   r_pop;
        logic [DRVRS-1:0]   r_push;
        logic [DRVRS-1:0]   w_pop_nxt;
        logic [DRVRS-1:0]   w_push_nxt;
        logic [DRVRS-1:0]   w_route;
        logic [7:0]         w_dest;

        // Search starts just after the last grant and wraps at DRVRS.
        always_comb begin
            w_found = 1'b0;
            w_grant = '0;
            w_idx   = '0;
            for (int k = 1; k <= DRVRS; k++) begin
                w_idx = {1'b0, r_rr} + (IW+1)'(k);
                if (w_idx >= (IW+1)'(DRVRS)) begin
                    w_idx = w_idx - (IW+1)'(DRVRS);
                end
                if (!w_found && pndng[b][w_idx[IW-1:0]]) begin
                    w_found = 1'b1;
                    w_grant = w_idx[IW-1:0];
                end
            end
        end

        always_comb begin
            w_dest  = r_pkt[PCKG_SZ-1 -: 8];
            w_route = '0;
            if (w_dest < 8'(DRVRS)) begin
                w_route[w_dest[IW-1:0]] = 1'b1;
            end else if (w_dest == BROADCAST) begin
`ifdef BCAST_SELF_EN
                w_route = '1;
`else
                w_route        = '1;
                w_route[r_src] = 1'b0;
`endif
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_pop_nxt   = '0;
            w_push_nxt  = '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        w_state_nxt        = ST_POP;
                        w_pop_nxt[w_grant] = 1'b1;
                    end
                end
                ST_POP: begin
                    w_state_nxt = ST_PUSH;
                    w_push_nxt  = w_route;
                end
                ST_PUSH: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= ST_IDLE;
                r_rr    <= IW'(DRVRS - 1);
                r_src   <= '0;
                r_pkt   <= '0;
                r_dpush <= '0;
                r_pop   <= '0;
                r_push  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_pop   <= w_pop_nxt;
                r_push  <= w_push_nxt;
                if (r_state == ST_IDLE && w_found) begin
                    r_pkt <= D_pop[b][w_grant];
                    r_src <= w_grant;
                    r_rr  <= w_grant;
                end
                if (r_state == ST_POP) begin
                    r_dpush <= r_pkt;
                end
            end
        end

        assign pop[b]  = r_pop;
        assign push[b] = r_push;

        for (genvar d = 0; d < DRVRS; d++) begin : g_drv
            assign D_push[b][d] = r_dpush;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_gnrtr_arbiter.sv
// ============================================================================
// Module      : tb_bus_gnrtr_arbiter
// Description : Scoreboard bench for bus_gnrtr_arbiter with DRVRS=8, PCKG_SZ=16.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_gnrtr_arbiter;

    localparam int BITS  = 1;
    localparam int DRVRS = 8;
    localparam int PSZ   = 16;

`ifdef BCAST_SELF_EN
    localparam logic [7:0] C_BCAST_PUSH = 8'hFF;
`else
    localparam logic [7:0] C_BCAST_PUSH = 8'b1111_0111;
`endif

    logic                              clk = 1'b0;
    logic                              reset = 1'b1;
    logic [BITS-1:0][DRVRS-1:0]        pndng;
    logic [BITS-1:0][DRVRS-1:0][PSZ-1:0] D_pop;
    logic [BITS-1:0][DRVRS-1:0]        pop;
    logic [BITS-1:0][DRVRS-1:0]        push;
    logic [BITS-1:0][DRVRS-1:0][PSZ-1:0] D_push;

    bus_gnrtr_arbiter #(
        .BITS     (BITS),
        .DRVRS    (DRVRS),
        .PCKG_SZ  (PSZ),
        .BROADCAST(8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pndng (pndng),
        .D_pop (D_pop),
        .pop   (pop),
        .push  (push),
        .D_push(D_push)
    );

    always #5 clk = ~clk;

    int ncmp  = 0;
    int nfail = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver FIFO model: first-word fall-through, dequeues on a sampled pop.
    logic [PSZ-1:0] fmem [DRVRS][4];
    int             fcnt [DRVRS];

    task automatic load(input int d, input logic [PSZ-1:0] pkt);
        fmem[d][fcnt[d]] = pkt;
        fcnt[d]++;
    endtask

    initial begin
        logic [DRVRS-1:0] smp;
        logic             rs;
        for (int d = 0; d < DRVRS; d++) fcnt[d] = 0;
        pndng = '0;
        D_pop = '0;
        forever begin
            @(posedge clk);
            smp = pop[0];
            rs  = reset;
            #1;
            for (int d = 0; d < DRVRS; d++) begin
                if (rs) begin
                    fcnt[d] = 0;
                end else if (smp[d] && fcnt[d] > 0) begin
                    for (int j = 0; j < 3; j++) fmem[d][j] = fmem[d][j+1];
                    fcnt[d]--;
                end
                pndng[0][d] = (fcnt[d] > 0);
                D_pop[0][d] = (fcnt[d] > 0) ? fmem[d][0] : '0;
            end
        end
    end

    typedef struct {
        logic [7:0]     pop;
        logic [7:0]     push;
        logic [PSZ-1:0] data;
        int             gap;
    } exp_t;

    exp_t q[$];
    logic mon_en   = 1'b0;
    logic mon_busy = 1'b0;
    int   last_pop = 0;

    task automatic add_exp(input logic [7:0] p, input logic [7:0] s, input logic [PSZ-1:0] d, input int g);
        exp_t e;
        e.pop = p; e.push = s; e.data = d; e.gap = g;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && !reset) begin
                if (pop[0] !== '0) begin
                    mon_busy = 1'b1;
                    if (q.size() == 0) begin
                        chk("unexpected_pop", pop[0], 0);
                    end else begin
                        e = q.pop_front();
                        chk("pop_vec", pop[0], e.pop);
                        if (e.gap != 0) chk("pop_spacing", cyc - last_pop, e.gap);
                        last_pop = cyc;
                        @(negedge clk);
                        chk("pop_one_cycle", pop[0], 0);
                        chk("push_vec", push[0], e.push);
                        chk("d_push", D_push[0], {DRVRS{e.data}});
                        @(negedge clk);
                        chk("push_one_cycle", push[0], 0);
                    end
                    mon_busy = 1'b0;
                end else if (push[0] !== '0) begin
                    chk("unexpected_push", push[0], 0);
                end
            end
        end
    end

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0 && !mon_busy) return;
        end
        chk("drain_timeout", q.size(), 0);
        q.delete();
    endtask

    initial begin
        logic [DRVRS-1:0] quiet;
        logic             seen;

        repeat (3) begin
            @(negedge clk);
            chk("rst_pop", pop, 0);
            chk("rst_push", push, 0);
            chk("rst_dpush", D_push, 0);
        end
        @(posedge clk);
        #3 reset = 1'b0;

        quiet = '0;
        repeat (20) begin
            @(negedge clk);
            quiet = quiet | pop[0] | push[0];
        end
        chk("idle_quiet", quiet, 0);

        #1 mon_en = 1'b1;

        add_exp(8'h04, 8'b0010_0000, 16'h05AB, 0);
        load(2, 16'h05AB);
        drain(20);

        add_exp(8'h01, 8'h00, 16'h0A00, 0);
        load(0, 16'h0A00);
        drain(20);

        add_exp(8'h02, 8'h40, 16'h0611, 0);
        add_exp(8'h40, 8'h02, 16'h0166, 3);
        add_exp(8'h02, 8'h40, 16'h0622, 3);
        add_exp(8'h40, 8'h02, 16'h0177, 3);
        load(1, 16'h0611);
        load(1, 16'h0622);
        load(6, 16'h0166);
        load(6, 16'h0177);
        drain(40);

        add_exp(8'h08, C_BCAST_PUSH, 16'hFF12, 0);
        load(3, 16'hFF12);
        drain(20);

        // Reset lands while driver 4 is in its pop cycle.
        mon_en = 1'b0;
        load(4, 16'h0134);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!seen && pop[0][4]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_mid_pop_seen", seen, 1);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_pop_clear", pop, 0);
        chk("rst_mid_push", push, 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_no_push", push, 0);
            chk("rst_mid_dpush", D_push, 0);
        end
        @(posedge clk);
        #3 reset = 1'b0;
        mon_en = 1'b1;

        add_exp(8'h01, 8'h01, 16'h0055, 0);
        add_exp(8'h20, 8'h80, 16'h07AA, 0);
        load(5, 16'h07AA);
        load(0, 16'h0055);
        drain(40);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
